// File: rtl/bip_control.sv
// Control unit of the BIP1 single-cycle processor.
// Owns the program counter, decodes the instruction returned by program
// memory, drives the datapath selects and memory strobes, and counts the
// RUN cycles executed up to and including HLT.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; PC held at 0, all decode outputs low
// RUN   | one instruction per cycle; PC and cycle counter advance
// HALT  | HLT executed; PC and cycle counter frozen until i_reset
module bip_control #(
   parameter int NB_INSTR   = 16,
   parameter int NB_OPCODE  = 5,
   parameter int NB_OPERAND = 11,
   parameter int NB_CNT     = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [NB_INSTR-1:0]   i_Instruction,
   output logic [NB_OPERAND-1:0] o_Addr_Prog,
   output logic [NB_OPERAND-1:0] o_Addr_Data,
   output logic [1:0]            o_SelA,
   output logic                  o_SelB,
   output logic                  o_WrAcc,
   output logic                  o_Op,
   output logic                  o_WrRam,
   output logic                  o_RdRam,
   output logic                  o_Halt,
   output logic                  o_Busy,
   output logic [NB_CNT-1:0]     o_Cycles
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
   localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
   localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
   localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
   localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
   localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
   localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
   localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

   state_t                r_state;
   state_t                w_state_next;
   logic [NB_OPERAND-1:0] r_pc;
   logic [NB_OPERAND-1:0] w_pc_next;
   logic [NB_CNT-1:0]     r_cycles;
   logic [NB_CNT-1:0]     w_cycles_next;
   logic [NB_CNT-1:0]     w_cycles_inc;
   logic [NB_OPCODE-1:0]  w_opcode;

   assign w_opcode     = i_Instruction[NB_INSTR-1 -: NB_OPCODE];
   assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + NB_CNT'(1);

   // State, PC and cycle counter registers; reset overrides start and halt
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_pc     <= '0;
         r_cycles <= '0;
      end else begin
         r_state  <= w_state_next;
         r_pc     <= w_pc_next;
         r_cycles <= w_cycles_next;
      end
   end

   // Next-state, PC and counter update; HLT counts its own cycle but keeps PC
   always_comb begin
      w_state_next  = r_state;
      w_pc_next     = r_pc;
      w_cycles_next = r_cycles;
      case (r_state)
         ST_IDLE: begin
            w_pc_next = '0;
            if (i_start) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_cycles_next = w_cycles_inc;
            if (w_opcode == OP_HLT) begin
               w_state_next = ST_HALT;
            end else begin
               w_pc_next = r_pc + NB_OPERAND'(1);
            end
         end
         ST_HALT: begin
            w_state_next = ST_HALT;
         end
         default: begin
            w_state_next = ST_IDLE;
            w_pc_next    = '0;
         end
      endcase
   end

   // Instruction decode; enables only ever assert while running
   always_comb begin
      o_SelA  = 2'd0;
      o_SelB  = 1'b0;
      o_WrAcc = 1'b0;
      o_Op    = 1'b0;
      o_WrRam = 1'b0;
      o_RdRam = 1'b0;
      if (r_state == ST_RUN) begin
         case (w_opcode)
            OP_STO: begin
               o_WrRam = 1'b1;
            end
            OP_LD: begin
               o_RdRam = 1'b1;
               o_SelA  = 2'd0;
               o_WrAcc = 1'b1;
            end
            OP_LDI: begin
               o_SelA  = 2'd1;
               o_WrAcc = 1'b1;
            end
            OP_ADD, OP_SUB: begin
               o_RdRam = 1'b1;
               o_SelB  = 1'b0;
               o_SelA  = 2'd2;
               o_Op    = (w_opcode == OP_SUB);
               o_WrAcc = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
               o_SelB  = 1'b1;
               o_SelA  = 2'd2;
               o_Op    = (w_opcode == OP_SUBI);
               o_WrAcc = 1'b1;
            end
            default: begin
               o_WrAcc = 1'b0;
            end
         endcase
      end
   end

   assign o_Addr_Prog = r_pc;
   assign o_Addr_Data = i_Instruction[NB_OPERAND-1:0];
   assign o_Halt      = (r_state == ST_HALT);
   assign o_Busy      = (r_state == ST_RUN);
   assign o_Cycles    = r_cycles;

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: table-driven programs whose per-cycle expected
// outputs are queued on start and popped at each falling edge, plus
// hand-written sequences for reset, wrap and counter saturation.
module tb_bip_control;

   typedef struct packed {
      logic [10:0] pc;
      logic [10:0] ad;
      logic [1:0]  sela;
      logic        selb;
      logic        wracc;
      logic        op;
      logic        wrram;
      logic        rdram;
      logic        halt;
      logic        busy;
      logic [15:0] cyc;
   } out_t;

   typedef struct {
      logic [10:0] addr;
      logic [15:0] instr;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] instr;
   logic [10:0] addr_prog, addr_data;
   logic [1:0]  sela;
   logic        selb, wracc, op, wrram, rdram, halt, busy;
   logic [15:0] cycles;

   logic        rst_s, start_s;
   logic [10:0] s_addr_prog, s_addr_data;
   logic [1:0]  s_sela;
   logic        s_selb, s_wracc, s_op, s_wrram, s_rdram, s_halt, s_busy;
   logic [3:0]  s_cycles;

   logic [15:0] prog [0:2047];
   vec_t        tbl[$];
   out_t        sb[$];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   assign instr = prog[addr_prog];

   bip_control dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_Instruction(instr),
      .o_Addr_Prog(addr_prog), .o_Addr_Data(addr_data), .o_SelA(sela),
      .o_SelB(selb), .o_WrAcc(wracc), .o_Op(op), .o_WrRam(wrram),
      .o_RdRam(rdram), .o_Halt(halt), .o_Busy(busy), .o_Cycles(cycles)
   );

   // narrow counter instance so saturation is reachable in a short run
   bip_control #(.NB_CNT(4)) dut_s (
      .i_clk(clk), .i_reset(rst_s), .i_start(start_s), .i_Instruction(16'h4000),
      .o_Addr_Prog(s_addr_prog), .o_Addr_Data(s_addr_data), .o_SelA(s_sela),
      .o_SelB(s_selb), .o_WrAcc(s_wracc), .o_Op(s_op), .o_WrRam(s_wrram),
      .o_RdRam(s_rdram), .o_Halt(s_halt), .o_Busy(s_busy), .o_Cycles(s_cycles)
   );

   function automatic out_t mk(input int pc, input int ad, input int sa,
                               input bit sb_, input bit wa, input bit o,
                               input bit wr, input bit rd, input bit h,
                               input bit b, input int cy);
      out_t m;
      m.pc = 11'(pc);   m.ad = 11'(ad);   m.sela = 2'(sa);
      m.selb = sb_;     m.wracc = wa;     m.op = o;
      m.wrram = wr;     m.rdram = rd;     m.halt = h;
      m.busy = b;       m.cyc = 16'(cy);
      return m;
   endfunction

   function automatic string fmt(input out_t m);
      return $sformatf("pc=%h ad=%h selA=%0d selB=%b wrAcc=%b op=%b wrRam=%b rdRam=%b halt=%b busy=%b cyc=%0d",
                       m.pc, m.ad, m.sela, m.selb, m.wracc, m.op, m.wrram,
                       m.rdram, m.halt, m.busy, m.cyc);
   endfunction

   task automatic chk(input string name, input out_t e);
      out_t a;
      a = {addr_prog, addr_data, sela, selb, wracc, op, wrram, rdram, halt, busy, cycles};
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %s | expected %s", name, fmt(a), fmt(e));
      end
   endtask

   task automatic chk_sat(input string name, input logic [3:0] e);
      total++;
      if (s_cycles !== e) begin
         bad++;
         $display("FAIL %s: got cyc=%0d expected cyc=%0d", name, s_cycles, e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_tbl();
      foreach (tbl[i]) prog[tbl[i].addr] = tbl[i].instr;
   endtask

   task automatic run_table(input string name);
      out_t e;
      load_tbl();
      foreach (tbl[i]) sb.push_back(tbl[i].exp);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(name, e);
         @(negedge clk);
      end
   endtask

   task automatic fill_p1();
      tbl.delete();
      tbl.push_back('{11'd0, 16'h1805, mk(0, 'h005, 1, 0, 1, 0, 0, 0, 0, 1, 0)});
      tbl.push_back('{11'd1, 16'h2803, mk(1, 'h003, 2, 1, 1, 0, 0, 0, 0, 1, 1)});
      tbl.push_back('{11'd2, 16'h0810, mk(2, 'h010, 0, 0, 0, 0, 1, 0, 0, 1, 2)});
      tbl.push_back('{11'd3, 16'h00AB, mk(3, 'h0AB, 0, 0, 0, 0, 0, 0, 0, 1, 3)});
      tbl.push_back('{11'd3, 16'h00AB, mk(3, 'h0AB, 0, 0, 0, 0, 0, 0, 1, 0, 4)});
   endtask

   initial begin
      out_t halt_rec;
      rst = 1'b1; start = 1'b0; rst_s = 1'b1; start_s = 1'b0;
      for (int i = 0; i < 2048; i++) prog[i] = 16'h4000;

      // reset then idle
      do_reset();
      for (int i = 0; i < 5; i++) begin
         chk("idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         @(negedge clk);
      end

      // straight-line program, then start ignored while halted
      fill_p1();
      run_table("straight");
      halt_rec = mk(3, 'h0AB, 0, 0, 0, 0, 0, 0, 1, 0, 4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("halt_ignores_start", halt_rec);
      @(negedge clk);
      chk("halt_frozen", halt_rec);

      // memory ops
      do_reset();
      tbl.delete();
      tbl.push_back('{11'd0, 16'h17FF, mk(0, 'h7FF, 0, 0, 1, 0, 0, 1, 0, 1, 0)});
      tbl.push_back('{11'd1, 16'h3001, mk(1, 'h001, 2, 0, 1, 1, 0, 1, 0, 1, 1)});
      tbl.push_back('{11'd2, 16'h0000, mk(2, 'h000, 0, 0, 0, 0, 0, 0, 0, 1, 2)});
      tbl.push_back('{11'd2, 16'h0000, mk(2, 'h000, 0, 0, 0, 0, 0, 0, 1, 0, 3)});
      run_table("memops");

      // ADD and SUBI
      do_reset();
      tbl.delete();
      tbl.push_back('{11'd0, 16'h2055, mk(0, 'h055, 2, 0, 1, 0, 0, 1, 0, 1, 0)});
      tbl.push_back('{11'd1, 16'h382A, mk(1, 'h02A, 2, 1, 1, 1, 0, 0, 0, 1, 1)});
      tbl.push_back('{11'd2, 16'h0000, mk(2, 'h000, 0, 0, 0, 0, 0, 0, 0, 1, 2)});
      tbl.push_back('{11'd2, 16'h0000, mk(2, 'h000, 0, 0, 0, 0, 0, 0, 1, 0, 3)});
      run_table("add_subi");

      // undefined opcode behaves as NOP
      do_reset();
      tbl.delete();
      tbl.push_back('{11'd0, 16'hA923, mk(0, 'h123, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
      tbl.push_back('{11'd1, 16'h0000, mk(1, 'h000, 0, 0, 0, 0, 0, 0, 0, 1, 1)});
      tbl.push_back('{11'd1, 16'h0000, mk(1, 'h000, 0, 0, 0, 0, 0, 0, 1, 0, 2)});
      run_table("undef_op");

      // reset in the third RUN cycle, then restart from address 0
      do_reset();
      fill_p1();
      load_tbl();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("midrst_c0", tbl[0].exp);
      @(negedge clk);
      chk("midrst_c1", tbl[1].exp);
      @(negedge clk);
      chk("midrst_c2", tbl[2].exp);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_idle", mk(0, 'h005, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_c0", tbl[0].exp);
      @(negedge clk);
      chk("restart_c1", tbl[1].exp);

      // reset and start together: reset wins
      do_reset();
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst_and_start", mk(0, 'h005, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk("rst_and_start_after", mk(0, 'h005, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // PC wrap on all-NOP memory, plus counter saturation on the narrow instance
      for (int i = 0; i < 2048; i++) prog[i] = 16'h4000;
      do_reset();
      rst_s = 1'b0;
      start = 1'b1; start_s = 1'b1;
      @(negedge clk);
      start = 1'b0; start_s = 1'b0;
      for (int k = 0; k <= 2049; k++) begin
         if (k == 0 || k == 2047 || k == 2048 || k == 2049)
            chk($sformatf("wrap_k%0d", k), mk(k % 2048, 0, 0, 0, 0, 0, 0, 0, 0, 1, k));
         if (k == 14 || k == 15 || k == 16 || k == 2049)
            chk_sat($sformatf("sat_k%0d", k), (k < 15) ? 4'(k) : 4'd15);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
